// File: rtl/mips_defs.sv
// Shared MIPS encoding constants used by the fetch/decode boundary logic.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BR,
    NPC_JMP,
    NPC_JR
  } npc_sel_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_gen.sv
// Combinational next-PC selection from the instruction held in D.
module npc_gen
  import mips_defs::*;
(
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCFD,
  input  logic        ValidD,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] NPC,
  output logic        taken
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] pc_seq;
  logic [31:0] pcd_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  npc_sel_e    sel;

  assign opcode      = InstrD[31:26];
  assign funct       = InstrD[5:0];
  assign imm16       = InstrD[15:0];
  assign instr_index = InstrD[25:0];

  assign pc_seq    = PCFD + 32'd4;
  assign pcd_plus4 = PCD + 32'd4;
  assign br_target = pcd_plus4 + branch_offset(imm16);
  assign j_target  = {pcd_plus4[31:28], instr_index, 2'b00};

  // A squashed or NOP slot in D never redirects.
  always_comb begin
    sel = NPC_SEQ;
    if (ValidD && (InstrD != NOP_WORD)) begin
      case (opcode)
        OP_BEQ:     if (rs_data == rt_data) sel = NPC_BR;
        OP_BNE:     if (rs_data != rt_data) sel = NPC_BR;
        OP_J,
        OP_JAL:     sel = NPC_JMP;
        OP_SPECIAL: if (funct == FUNCT_JR) sel = NPC_JR;
        default:    sel = NPC_SEQ;
      endcase
    end
  end

  always_comb begin
    NPC = pc_seq;
    case (sel)
      NPC_BR:  NPC = br_target;
      NPC_JMP: NPC = j_target;
      NPC_JR:  NPC = rs_data;
      default: NPC = pc_seq;
    endcase
  end

  assign taken = (sel != NPC_SEQ);

endmodule

// File: rtl/fd_stage.sv
// F/D pipeline register with redirect squash and saturating stall counter.
// Build option: define FD_DELAY_SLOT_EN for MIPS delay-slot semantics (no squash).
module fd_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          STALLCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           InstrFD,
  input  logic [31:0]           PCFD,
  input  logic                  stall,
  input  logic [31:0]           rs_data,
  input  logic [31:0]           rt_data,
  output logic                  EnPC,
  output logic [31:0]           NPC,
  output logic [31:0]           InstrD,
  output logic [31:0]           PCD,
  output logic                  ValidD,
  output logic [STALLCNT_W-1:0] StallCnt
);

  localparam logic [STALLCNT_W-1:0] CNT_ONE = {{(STALLCNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALLCNT_W-1:0] CNT_MAX = {STALLCNT_W{1'b1}};

  logic taken;

  npc_gen u_npc_gen (
    .InstrD  (InstrD),
    .PCD     (PCD),
    .PCFD    (PCFD),
    .ValidD  (ValidD),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .NPC     (NPC),
    .taken   (taken)
  );

  assign EnPC = ~stall;

`ifdef FD_DELAY_SLOT_EN
  // The slot after a taken redirect executes, so the redirect never kills F.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD <= NOP_WORD;
      PCD    <= RESET_PC;
      ValidD <= 1'b0;
    end else if (!stall) begin
      InstrD <= InstrFD;
      PCD    <= PCFD;
      ValidD <= 1'b1;
    end
  end

  logic unused_taken;
  assign unused_taken = taken;
`else
  // Redirect is only committed once stall drops; while stalled it is re-evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD <= NOP_WORD;
      PCD    <= RESET_PC;
      ValidD <= 1'b0;
    end else if (!stall) begin
      if (taken) begin
        InstrD <= NOP_WORD;
        PCD    <= PCFD;
        ValidD <= 1'b0;
      end else begin
        InstrD <= InstrFD;
        PCD    <= PCFD;
        ValidD <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
    end else if (stall && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fd_stage.sv
// Directed, table-driven bench for fd_stage plus stall/reset/saturation sequences.
module tb_fd_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] InstrFD = '0;
  logic [31:0] PCFD = '0;
  logic        stall = 1'b0;
  logic        sat_stall = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;

  logic        EnPC;
  logic [31:0] NPC;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic        ValidD;
  logic [15:0] StallCnt;

  logic        s_EnPC;
  logic [31:0] s_NPC;
  logic [31:0] s_InstrD;
  logic [31:0] s_PCD;
  logic        s_ValidD;
  logic [3:0]  s_StallCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fd_stage dut (
    .clk(clk), .reset(reset), .InstrFD(InstrFD), .PCFD(PCFD), .stall(stall),
    .rs_data(rs_data), .rt_data(rt_data), .EnPC(EnPC), .NPC(NPC),
    .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD), .StallCnt(StallCnt)
  );

  fd_stage #(.STALLCNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .InstrFD(InstrFD), .PCFD(PCFD), .stall(sat_stall),
    .rs_data(rs_data), .rt_data(rt_data), .EnPC(s_EnPC), .NPC(s_NPC),
    .InstrD(s_InstrD), .PCD(s_PCD), .ValidD(s_ValidD), .StallCnt(s_StallCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcf;
    logic        stl;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] npc;
    logic        sq;
    logic [31:0] e_instr;
    logic [31:0] e_pcd;
    logic        e_valid;
  } vec_t;

  vec_t vecs[16];

  function automatic logic is_ds();
`ifdef FD_DELAY_SLOT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic [31:0] ei, ep;
    logic        ev;

    // instr, pcf, stall, rs, rt, npc, squash-row, InstrD, PCD, ValidD (non-delay build)
    vecs[0]  = '{32'h2001_0001, 32'h3000, 1'b0, 32'h0,    32'h0, 32'h3004, 1'b0, 32'h2001_0001, 32'h3000, 1'b1};
    vecs[1]  = '{32'h2002_0002, 32'h3004, 1'b0, 32'h0,    32'h0, 32'h3008, 1'b0, 32'h2002_0002, 32'h3004, 1'b1};
    vecs[2]  = '{32'h2003_0003, 32'h3008, 1'b0, 32'h0,    32'h0, 32'h300C, 1'b0, 32'h2003_0003, 32'h3008, 1'b1};
    vecs[3]  = '{32'h2004_0004, 32'h300C, 1'b0, 32'h0,    32'h0, 32'h3010, 1'b0, 32'h2004_0004, 32'h300C, 1'b1};
    vecs[4]  = '{32'h1022_FFFC, 32'h3010, 1'b0, 32'h5,    32'h5, 32'h3014, 1'b0, 32'h1022_FFFC, 32'h3010, 1'b1};
    vecs[5]  = '{32'h2005_0005, 32'h3014, 1'b0, 32'h5,    32'h5, 32'h3004, 1'b1, 32'h0,         32'h3014, 1'b0};
    vecs[6]  = '{32'h1422_0004, 32'h3018, 1'b0, 32'h7,    32'h7, 32'h301C, 1'b0, 32'h1422_0004, 32'h3018, 1'b1};
    vecs[7]  = '{32'h03E0_0008, 32'h301C, 1'b0, 32'h7,    32'h7, 32'h3020, 1'b0, 32'h03E0_0008, 32'h301C, 1'b1};
    vecs[8]  = '{32'h2006_0006, 32'h3020, 1'b0, 32'h3400, 32'h0, 32'h3400, 1'b1, 32'h0,         32'h3020, 1'b0};
    vecs[9]  = '{32'h0800_0C10, 32'h3000, 1'b0, 32'h0,    32'h0, 32'h3004, 1'b0, 32'h0800_0C10, 32'h3000, 1'b1};
    vecs[10] = '{32'h2007_0007, 32'h3040, 1'b0, 32'h0,    32'h0, 32'h3040, 1'b1, 32'h0,         32'h3040, 1'b0};
    vecs[11] = '{32'h0C00_0C10, 32'h3044, 1'b0, 32'h0,    32'h0, 32'h3048, 1'b0, 32'h0C00_0C10, 32'h3044, 1'b1};
    vecs[12] = '{32'h2008_0008, 32'h3000, 1'b0, 32'h0,    32'h0, 32'h3040, 1'b1, 32'h0,         32'h3000, 1'b0};
    vecs[13] = '{32'h1422_0004, 32'h3100, 1'b0, 32'h1,    32'h2, 32'h3104, 1'b0, 32'h1422_0004, 32'h3100, 1'b1};
    vecs[14] = '{32'h2009_0009, 32'h3104, 1'b0, 32'h1,    32'h2, 32'h3114, 1'b1, 32'h0,         32'h3104, 1'b0};
    vecs[15] = '{32'h200A_000A, 32'h3108, 1'b0, 32'h0,    32'h0, 32'h310C, 1'b0, 32'h200A_000A, 32'h3108, 1'b1};

    // Reset asserted between edges must take effect immediately.
    #2 reset = 1'b1;
    #1;
    chk("rst_instrd", InstrD, 32'h0);
    chk("rst_pcd", PCD, 32'h3000);
    chk("rst_validd", {31'h0, ValidD}, 32'h0);
    chk("rst_stallcnt", {16'h0, StallCnt}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset   = 1'b0;
      InstrFD = vecs[i].instr;
      PCFD    = vecs[i].pcf;
      stall   = vecs[i].stl;
      rs_data = vecs[i].rs;
      rt_data = vecs[i].rt;
      #1;
      chk($sformatf("v%0d_npc", i), NPC, vecs[i].npc);
      chk($sformatf("v%0d_enpc", i), {31'h0, EnPC}, {31'h0, ~vecs[i].stl});
      @(posedge clk);
      #1;
      ei = vecs[i].e_instr;
      ep = vecs[i].e_pcd;
      ev = vecs[i].e_valid;
      if (vecs[i].sq && is_ds()) begin
        ei = vecs[i].instr;
        ev = 1'b1;
      end
      chk($sformatf("v%0d_instrd", i), InstrD, ei);
      chk($sformatf("v%0d_pcd", i), PCD, ep);
      chk($sformatf("v%0d_validd", i), {31'h0, ValidD}, {31'h0, ev});
    end

    // Taken beq held in D across a three-cycle stall, squashed when stall falls.
    @(negedge clk);
    InstrFD = 32'h1022_FFFC; PCFD = 32'h3010; stall = 1'b0; rs_data = 32'h5; rt_data = 32'h5;
    @(posedge clk); #1;
    chk("stl_load_instrd", InstrD, 32'h1022_FFFC);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      InstrFD = 32'h200B_000B; PCFD = 32'h3014; stall = 1'b1;
      #1;
      chk($sformatf("stl%0d_enpc", k), {31'h0, EnPC}, 32'h0);
      chk($sformatf("stl%0d_npc", k), NPC, 32'h3004);
      @(posedge clk); #1;
      chk($sformatf("stl%0d_instrd", k), InstrD, 32'h1022_FFFC);
      chk($sformatf("stl%0d_pcd", k), PCD, 32'h3010);
      chk($sformatf("stl%0d_validd", k), {31'h0, ValidD}, 32'h1);
    end
    chk("stl_cnt3", {16'h0, StallCnt}, 32'd3);
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("unstl_npc", NPC, 32'h3004);
    chk("unstl_enpc", {31'h0, EnPC}, 32'h1);
    @(posedge clk); #1;
    chk("unstl_instrd", InstrD, is_ds() ? 32'h200B_000B : 32'h0);
    chk("unstl_pcd", PCD, 32'h3014);
    chk("unstl_validd", {31'h0, ValidD}, is_ds() ? 32'h1 : 32'h0);
    chk("unstl_cnt", {16'h0, StallCnt}, 32'd3);

    // Reset in the middle of a stall abandons it; first edge after release loads F.
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk); #1;
    chk("mid_cnt4", {16'h0, StallCnt}, 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_instrd", InstrD, 32'h0);
    chk("mid_rst_pcd", PCD, 32'h3000);
    chk("mid_rst_validd", {31'h0, ValidD}, 32'h0);
    chk("mid_rst_cnt", {16'h0, StallCnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; InstrFD = 32'h2001_0001; PCFD = 32'h3000;
    rs_data = 32'h0; rt_data = 32'h0;
    #1;
    chk("rel_npc", NPC, 32'h3004);
    @(posedge clk); #1;
    chk("rel_instrd", InstrD, 32'h2001_0001);
    chk("rel_pcd", PCD, 32'h3000);
    chk("rel_validd", {31'h0, ValidD}, 32'h1);

    // Saturation on the 4-bit counter instance.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      sat_stall = 1'b1;
      @(posedge clk); #1;
      if (n == 13) chk("sat_14", {28'h0, s_StallCnt}, 32'd14);
      if (n == 14) chk("sat_15", {28'h0, s_StallCnt}, 32'd15);
      if (n == 19) chk("sat_hold", {28'h0, s_StallCnt}, 32'd15);
    end
    chk("sat_enpc", {31'h0, s_EnPC}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
